// File: rtl/sp_ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sp_ram_arb_pkg
// Shared types and helpers for the sp_ram request-port arbiter.
//   MAX_MASTERS     : upper bound on the number of requesters
//   master_id_t     : encoded master index, wide enough for MAX_MASTERS
//   req_bundle_t    : one master's request payload (addr, we, wdata)
//   next_id()       : round-robin successor of a master index, modulo n
// ----------------------------------------------------------------------------
package sp_ram_arb_pkg;

   localparam int MAX_MASTERS    = 8;
   localparam int MAX_ADDR_WIDTH = 64;
   localparam int MAX_DATA_WIDTH = 64;

   typedef logic [$clog2(MAX_MASTERS)-1:0] master_id_t;

   typedef struct packed {
      logic [MAX_ADDR_WIDTH-1:0] addr;
      logic                      we;
      logic [MAX_DATA_WIDTH-1:0] wdata;
   } req_bundle_t;

   // Successor of id in a ring of n masters (n-1 wraps back to 0).
   function automatic master_id_t next_id(input master_id_t id, input int unsigned n);
      if (id == master_id_t'(n - 1)) begin
         next_id = '0;
      end else begin
         next_id = id + 3'd1;
      end
   endfunction

endpackage

// File: rtl/sp_ram_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector. Searches the request vector
// starting at the priority pointer and wrapping modulo N; the first set bit
// wins.
//   req    : per-master request vector
//   prio   : index searched first
//   gnt    : one-hot winner (all zero when nobody requests)
//   winner : encoded winner index (0 when nobody requests)
//   valid  : at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  master_id_t   prio,
   output logic [N-1:0] gnt,
   output master_id_t   winner,
   output logic         valid
);

   // Rotating priority search: offset k from prio maps to master (prio+k) mod N.
   always_comb begin
      logic hit;
      gnt    = '0;
      winner = '0;
      valid  = 1'b0;
      hit    = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            hit    = !valid && req[j] && (((int'(prio) + k) % N) == j);
            winner = hit ? master_id_t'(j) : winner;
            gnt[j] = gnt[j] | hit;
            valid  = valid | hit;
         end
      end
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// ----------------------------------------------------------------------------
// sp_ram_arbiter
// Shares the single sp_ram request port between NUM_MASTERS requesters using
// round-robin arbitration. Memory grants in the request cycle and returns
// rvalid one cycle later; the arbiter remembers the owner of that pending
// response and steers rvalid back to it. Read data is captured in the grant
// cycle because sp_ram read data follows the current address combinationally.
//   m_req_i/m_gnt_o/m_rvalid_o : per-master handshake
//   m_addr_i/m_we_i/m_wdata_i  : per-master request payload
//   m_rdata_o                  : captured read data, broadcast to every master
//   mem_*                      : single port towards sp_ram
//   stray_rvalid_o             : sticky, rvalid seen with nothing pending
// ----------------------------------------------------------------------------
module sp_ram_arbiter
   import sp_ram_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_MASTERS-1:0]                 m_req_i,
   output logic [NUM_MASTERS-1:0]                 m_gnt_o,
   output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
   input  logic [NUM_MASTERS-1:0]                 m_we_i,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
   output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata_o,
   output logic                                   mem_req_o,
   input  logic                                   mem_gnt_i,
   input  logic                                   mem_rvalid_i,
   output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
   output logic                                   mem_we_o,
   output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
   output logic                                   stray_rvalid_o
);

   master_id_t             prio_r;
   master_id_t             owner_r;
   logic                   pend_r;
   logic                   stray_r;
   logic [DATA_WIDTH-1:0]  rdata_r;

   master_id_t             winner_s;
   logic                   valid_s;
   logic                   hs_s;
   logic [NUM_MASTERS-1:0] onehot_s;

   rr_arbiter #(.N(NUM_MASTERS)) u_rr (
      .req    (m_req_i),
      .prio   (prio_r),
      .gnt    (onehot_s),
      .winner (winner_s),
      .valid  (valid_s)
   );

   assign mem_req_o      = |m_req_i;
   assign hs_s           = valid_s && mem_gnt_i;
   assign m_gnt_o        = onehot_s & {NUM_MASTERS{mem_gnt_i}};
   assign stray_rvalid_o = stray_r;

   // Winner payload mux; AND-OR over the one-hot grant so idle cycles drive 0.
   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         mem_addr_o  = mem_addr_o  | (m_addr_i[i]  & {ADDR_WIDTH{onehot_s[i]}});
         mem_we_o    = mem_we_o    | (m_we_i[i]    & onehot_s[i]);
         mem_wdata_o = mem_wdata_o | (m_wdata_i[i] & {DATA_WIDTH{onehot_s[i]}});
      end
   end

   // Response steering: only the recorded owner sees rvalid; data is shared.
   always_comb begin
      m_rvalid_o = '0;
      m_rdata_o  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         m_rvalid_o[i] = pend_r && mem_rvalid_i && (owner_r == master_id_t'(i));
         m_rdata_o[i]  = rdata_r;
      end
   end

   // Pointer, pending-owner tracking, read-data capture and sticky stray flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_r  <= '0;
         owner_r <= '0;
         pend_r  <= 1'b0;
         rdata_r <= '0;
         stray_r <= 1'b0;
      end else begin
         if (hs_s) begin
            prio_r  <= next_id(winner_s, NUM_MASTERS);
            owner_r <= winner_s;
            pend_r  <= 1'b1;
            rdata_r <= mem_rdata_i;
         end else begin
            pend_r  <= 1'b0;
         end
         stray_r <= stray_r | (mem_rvalid_i & ~pend_r);
      end
   end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
module tb_sp_ram_arbiter;
   import sp_ram_arb_pkg::*;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NM-1:0]         m_req_i, m_gnt_o, m_rvalid_o, m_we_i;
   logic [NM-1:0][AW-1:0] m_addr_i;
   logic [NM-1:0][DW-1:0] m_wdata_i, m_rdata_o;
   logic                  mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, stray_rvalid_o;
   logic [AW-1:0]         mem_addr_o;
   logic [DW-1:0]         mem_wdata_o, mem_rdata_i;

   sp_ram_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
      .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i), .stray_rvalid_o(stray_rvalid_o)
   );

   // Small sp_ram: 16 words, combinational read, write on handshake.
   logic [DW-1:0] mem [16];
   logic          mem_init;
   assign mem_rdata_i = mem[mem_addr_o[3:0]];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h11 + i;
      end else if (mem_req_o && mem_gnt_i && mem_we_o) begin
         mem[mem_addr_o[3:0]] <= mem_wdata_o;
      end
   end

   int checks = 0;
   int failures = 0;

   // Reference model state
   int            m_prio, m_owner;
   bit            m_pend, m_stray;
   logic [DW-1:0] m_rdata;
   int            st_w;
   bit            st_hs, st_stray, inj_stray;
   logic [DW-1:0] st_rdata;
   logic [NM-1:0] last_gnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare every output against the model for the current inputs and stage the next state.
   task automatic eval_cycle();
      int w;
      int idx;
      logic [NM-1:0] eg, erv;
      #1;
      w = -1;
      for (int k = 0; k < NM; k++) begin
         idx = (m_prio + k) % NM;
         if (w < 0 && m_req_i[idx]) w = idx;
      end
      eg = '0;
      if (w >= 0 && mem_gnt_i) eg[w] = 1'b1;
      erv = '0;
      if (m_pend && mem_rvalid_i) erv[m_owner] = 1'b1;
      chk("mem_req", mem_req_o, |m_req_i);
      chk("gnt", m_gnt_o, eg);
      chk("rvalid", m_rvalid_o, erv);
      chk("stray", stray_rvalid_o, m_stray);
      for (int i = 0; i < NM; i++) chk("rdata", m_rdata_o[i], m_rdata);
      if (w >= 0) begin
         chk("mem_addr", mem_addr_o, m_addr_i[w]);
         chk("mem_we", mem_we_o, m_we_i[w]);
         chk("mem_wdata", mem_wdata_o, m_wdata_i[w]);
      end else begin
         chk("mem_addr_idle", mem_addr_o, 0);
         chk("mem_we_idle", mem_we_o, 0);
         chk("mem_wdata_idle", mem_wdata_o, 0);
      end
      st_hs    = (w >= 0) && mem_gnt_i;
      st_w     = w;
      st_rdata = m_rdata;
      if (st_hs) st_rdata = mem[m_addr_i[w][3:0]];
      st_stray = m_stray | (mem_rvalid_i && !m_pend);
      last_gnt = eg;
   endtask

   // Commit the staged model state and move to the next cycle.
   task automatic adv_cycle();
      if (st_hs) begin
         m_prio  = (st_w + 1) % NM;
         m_owner = st_w;
         m_pend  = 1'b1;
         m_rdata = st_rdata;
      end else begin
         m_pend  = 1'b0;
      end
      m_stray = st_stray;
      @(posedge clk);
      #1;
      mem_rvalid_i = st_hs | (inj_stray & ~st_hs);
      inj_stray = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_req_i = '0;
      mem_gnt_i = 1'b1;
      mem_init = 1'b1;
      #1;
      chk("rst_gnt", m_gnt_o, 0);
      chk("rst_rvalid", m_rvalid_o, 0);
      chk("rst_rdata0", m_rdata_o[0], 0);
      chk("rst_rdata1", m_rdata_o[1], 0);
      chk("rst_stray", stray_rvalid_o, 0);
      chk("rst_mem_req", mem_req_o, 0);
      mem_rvalid_i = 1'b0;
      inj_stray = 1'b0;
      m_prio = 0; m_owner = 0; m_pend = 1'b0; m_stray = 1'b0; m_rdata = '0;
      st_hs = 1'b0; st_stray = 1'b0; last_gnt = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mem_init = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_init = 1'b1; inj_stray = 1'b0;
      @(negedge clk);
      do_reset();

      // Single master read of word 4
      m_req_i = 2'b01; m_addr_i[0] = 32'd4; m_we_i = 2'b00;
      eval_cycle(); chk("single_gnt", m_gnt_o, 2'b01); adv_cycle();
      m_req_i = 2'b00;
      eval_cycle(); chk("single_rvalid", m_rvalid_o, 2'b01);
      chk("single_rdata", m_rdata_o[0], 32'h15); adv_cycle();

      // Contention from reset: grants 0,1,0
      do_reset();
      m_req_i = 2'b11; m_addr_i[0] = 32'd1; m_addr_i[1] = 32'd2; m_we_i = 2'b00;
      for (int c = 0; c < 3; c++) begin
         eval_cycle();
         chk("cont_gnt", m_gnt_o, (c % 2 == 0) ? 2'b01 : 2'b10);
         if (c == 1) begin
            chk("cont_rv1", m_rvalid_o, 2'b01);
            chk("cont_rd1", m_rdata_o[0], 32'h12);
         end else if (c == 2) begin
            chk("cont_rv2", m_rvalid_o, 2'b10);
            chk("cont_rd2", m_rdata_o[1], 32'h13);
         end
         adv_cycle();
      end
      m_req_i = 2'b00;
      eval_cycle(); chk("cont_rv3", m_rvalid_o, 2'b01); adv_cycle();

      // m1 writes, then m0 reads the same word
      m_req_i = 2'b10; m_addr_i[1] = 32'd0; m_we_i = 2'b10; m_wdata_i[1] = 32'hDEAD_BEEF;
      eval_cycle(); chk("wr_gnt", m_gnt_o, 2'b10); adv_cycle();
      m_req_i = 2'b01; m_addr_i[0] = 32'd0; m_we_i = 2'b00;
      eval_cycle(); chk("rd_gnt", m_gnt_o, 2'b01); chk("wr_rvalid", m_rvalid_o, 2'b10); adv_cycle();
      m_req_i = 2'b00;
      eval_cycle(); chk("rd_rvalid", m_rvalid_o, 2'b01);
      chk("rd_data", m_rdata_o[0], 32'hDEAD_BEEF); adv_cycle();

      // m1 withdraws before being granted
      m_req_i = 2'b11; mem_gnt_i = 1'b0; m_addr_i[0] = 32'd3; m_addr_i[1] = 32'd7;
      eval_cycle(); chk("wd_nognt", m_gnt_o, 2'b00); adv_cycle();
      m_req_i = 2'b01; mem_gnt_i = 1'b1;
      eval_cycle(); chk("wd_gnt", m_gnt_o, 2'b01); adv_cycle();
      m_req_i = 2'b00;
      eval_cycle(); chk("wd_rvalid", m_rvalid_o, 2'b01); adv_cycle();

      // Stray rvalid with nothing pending
      inj_stray = 1'b1;
      eval_cycle(); adv_cycle();
      eval_cycle(); chk("stray_rvalid", m_rvalid_o, 2'b00); adv_cycle();
      eval_cycle(); chk("stray_set", stray_rvalid_o, 1'b1); adv_cycle();

      // Randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int m = 0; m < NM; m++) begin
            if (m_req_i[m] && !last_gnt[m]) begin
               if ($urandom_range(0, 19) == 0) m_req_i[m] = 1'b0;
            end else begin
               m_req_i[m]   = ($urandom_range(0, 2) != 0);
               m_addr_i[m]  = $urandom_range(0, 15);
               m_we_i[m]    = ($urandom_range(0, 3) == 0);
               m_wdata_i[m] = $urandom;
            end
         end
         mem_gnt_i = ($urandom_range(0, 3) != 0);
         inj_stray = ($urandom_range(0, 49) == 0);
         eval_cycle();
         adv_cycle();
      end

      // Reset on the cycle after a grant
      m_req_i = 2'b01; m_addr_i[0] = 32'd5; m_we_i = 2'b00; mem_gnt_i = 1'b1;
      eval_cycle(); chk("mid_gnt", m_gnt_o, 2'b01); adv_cycle();
      do_reset();
      m_req_i = 2'b11;
      eval_cycle(); chk("post_rst_gnt", m_gnt_o, 2'b01); chk("post_rst_rv", m_rvalid_o, 2'b00); adv_cycle();
      m_req_i = 2'b00;
      eval_cycle(); adv_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
